prog_loader: RTL and testbench

Program loader and checker that owns the CPU's main memory port while the CPU is not running. In the IN state it accepts program bytes over a valid/ready handshake and writes them to consecutive memory addresses from 0. In the CHECK state it reads them back one at a time for display. It is the writer/reader-back for the memory image the control unit later fetches in RUN, and it sits beside the control unit on the memory-port mux.

---
 rtl/prog_loader_if.sv | 31 +++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-input, read-back and memory-port signals of the program loader.
interface prog_loader_if #(
    parameter int AW = 16
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          chk_next;
    logic          chk_valid;
    logic [7:0]    chk_data;
    logic [AW-1:0] chk_addr;
    logic          chk_empty;
    logic          mem_own;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_rdata;

    modport slave (
        input  in_valid, in_data, chk_next, mem_rdata,
        output in_ready, chk_valid, chk_data, chk_addr, chk_empty,
               mem_own, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output in_valid, in_data, chk_next, mem_rdata,
        input  in_ready, chk_valid, chk_data, chk_addr, chk_empty,
               mem_own, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader/checker: writes bytes to memory from address 0 while the CPU
// is in IN, and reads them back one at a time for display while in CHECK.
module prog_loader #(
    parameter int AW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   cpustate,
    output logic [AW:0]  count,
    output logic         full,
    prog_loader_if.slave bus
);
    localparam logic [1:0] CS_IDLE  = 2'b00;
    localparam logic [1:0] CS_IN    = 2'b01;
    localparam logic [1:0] CS_CHECK = 2'b10;
    localparam logic [1:0] CS_RUN   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHK_REQ, S_CHK_WAIT, S_CHK_SHOW} state_t;

    state_t        state, state_n;
    logic [1:0]    prev_cs;
    logic [AW-1:0] wptr, rptr, rd_addr;
    logic [AW:0]   rptr_nx;
    logic          rd_q;
    logic          go_idle, enter_in, enter_chk;
    logic          hs, issue, capture, advance;

    assign go_idle   = (cpustate == CS_IDLE) || (cpustate == CS_RUN);
    assign enter_in  = (cpustate == CS_IN) && (prev_cs != CS_IN);
    assign enter_chk = (cpustate == CS_CHECK) && (prev_cs != CS_CHECK);
    assign full      = count[AW];
    assign rd_addr   = enter_chk ? '0 : rptr;
    assign rptr_nx   = {1'b0, rptr} + (AW+1)'(1);

    assign bus.in_ready = (state == S_LOAD) && (cpustate == CS_IN) && !full;
    assign bus.mem_own  = reset && ((cpustate == CS_IN) || (cpustate == CS_CHECK));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Entering CHECK issues the read for address 0 on the entry edge; after
    // chk_next the advanced rptr is issued from CHK_REQ one edge later.
    always_comb begin
        state_n = state;
        hs      = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        if (go_idle) begin
            state_n = S_IDLE;
        end else if (enter_in) begin
            state_n = S_LOAD;
        end else if (enter_chk) begin
            if (count == '0) begin
                state_n = S_IDLE;
            end else begin
                state_n = S_CHK_REQ;
                issue   = 1'b1;
            end
        end else begin
            case (state)
                S_LOAD:     hs = bus.in_valid && bus.in_ready;
                S_CHK_REQ:  if (bus.mem_re) state_n = S_CHK_WAIT;
                            else            issue   = 1'b1;
                S_CHK_WAIT: if (rd_q) begin
                                capture = 1'b1;
                                state_n = S_CHK_SHOW;
                            end
                S_CHK_SHOW: if (bus.chk_next) begin
                                advance = 1'b1;
                                state_n = S_CHK_REQ;
                            end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_cs       <= CS_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rd_q          <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.chk_valid <= 1'b0;
            bus.chk_data  <= '0;
            bus.chk_addr  <= '0;
            bus.chk_empty <= 1'b0;
        end else begin
            prev_cs       <= cpustate;
            bus.mem_we    <= hs;
            bus.mem_re    <= issue;
            // read data is valid the cycle after the strobe; an abort drops it
            rd_q          <= bus.mem_re && (state_n == S_CHK_WAIT);
            bus.chk_empty <= (cpustate == CS_CHECK) && (count == '0);

            if (hs) begin
                bus.mem_addr  <= wptr;
                bus.mem_wdata <= bus.in_data;
                wptr          <= wptr + AW'(1);
                count         <= count + (AW+1)'(1);
            end else if (issue) begin
                bus.mem_addr  <= rd_addr;
            end

            if (enter_in) begin
                wptr  <= '0;
                count <= '0;
            end

            if (enter_chk)    rptr <= '0;
            else if (advance) rptr <= (rptr_nx == count) ? '0 : rptr_nx[AW-1:0];

            if (go_idle || enter_in || advance) begin
                bus.chk_valid <= 1'b0;
            end else if (capture) begin
                bus.chk_valid <= 1'b1;
                bus.chk_data  <= bus.mem_rdata;
                bus.chk_addr  <= rptr;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random loads/read-backs against a byte-image model.
module tb_prog_loader;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;
    localparam logic [1:0] CS_IDLE = 2'b00, CS_IN = 2'b01, CS_CHECK = 2'b10, CS_RUN = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cpustate = CS_IDLE;
    logic [AW:0] count;
    logic        full;

    prog_loader_if #(.AW(AW)) bus();
    prog_loader #(.AW(AW)) dut (.clk(clk), .reset(reset), .cpustate(cpustate),
                                .count(count), .full(full), .bus(bus));

    always #5 clk = ~clk;

    // memory beside the loader, plus a log of every write strobe seen
    logic [7:0]    mem  [CAP];
    logic [AW+7:0] wlog [1024];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wlog[wr_cnt]      <= {bus.mem_addr, bus.mem_wdata};
            wr_cnt            <= wr_cnt + 1;
        end
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] img [$];    // model: bytes the loader should hold, in address order
    logic [7:0] src [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cpustate = m;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.in_ready, bus.chk_valid, bus.chk_data, bus.chk_addr, bus.chk_empty,
                    bus.mem_own, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, full}, 0);
        check({tag, "_count"}, count, 0);
    endtask

    task automatic load_bytes(input logic [7:0] bytes [$], input bit gaps);
        int base;
        set_mode(CS_IN);
        img.delete();
        base = wr_cnt;
        foreach (bytes[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            bus.in_valid = 1'b1;
            bus.in_data  = bytes[i];
            #1 check("in_ready", bus.in_ready, img.size() < CAP);
            step();
            bus.in_valid = 1'b0;
            if (img.size() < CAP) begin
                img.push_back(bytes[i]);
                check("wr_strobe", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                      {1'b1, AW'(img.size() - 1), bytes[i]});
                check("count", count, img.size());
            end else begin
                check("wr_when_full", bus.mem_we, 0);
            end
        end
        step();
        check("wr_total", wr_cnt - base, img.size());
        for (int i = 0; i < img.size(); i++)
            check("wr_log", wlog[base + i], {AW'(i), img[i]});
        check("full", full, img.size() == CAP);
        check("count_end", count, img.size());
        check("in_ready_end", bus.in_ready, img.size() < CAP);
    endtask

    task automatic check_run(input int steps, input bit rnd_delay);
        int idx = 0;
        int lat;
        set_mode(CS_CHECK);
        check("rd_issue", {bus.mem_re, bus.mem_addr, bus.chk_valid}, {1'b1, AW'(0), 1'b0});
        step();
        check("rd_wait", {bus.mem_re, bus.chk_valid}, 0);
        step();
        check("show0", {bus.chk_valid, bus.chk_addr, bus.chk_data}, {1'b1, AW'(0), img[0]});
        for (int s = 0; s < steps; s++) begin
            if (rnd_delay) repeat ($urandom_range(0, 3)) step();
            check("hold", {bus.chk_valid, bus.chk_addr, bus.chk_data}, {1'b1, AW'(idx), img[idx]});
            idx = (idx + 1) % img.size();
            bus.chk_next = 1'b1;
            step();
            bus.chk_next = 1'b0;
            lat = 0;
            while (!bus.chk_valid && lat < 8) begin
                step();
                lat++;
            end
            check("next_lat", lat, 3);
            check("show", {bus.chk_valid, bus.chk_addr, bus.chk_data}, {1'b1, AW'(idx), img[idx]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.chk_next = 1'b0;
        #12;
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // directed load and read-back with wrap
        src = '{8'hA5, 8'h3C, 8'hFF};
        load_bytes(src, 1'b0);
        check_run(4, 1'b0);

        // fill to capacity; the 17th byte must be dropped
        src.delete();
        for (int i = 0; i <= CAP; i++) src.push_back(8'(i));
        load_bytes(src, 1'b0);
        check_run(CAP + 1, 1'b1);

        // random loads with gaps, random read-back walks
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 20);
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(8'($urandom));
            load_bytes(src, 1'b1);
            check_run($urandom_range(1, 2 * n), 1'b1);
        end

        // abort CHECK to RUN while the read is in flight
        src = '{8'h11, 8'h22, 8'h33};
        load_bytes(src, 1'b0);
        set_mode(CS_IDLE);
        set_mode(CS_CHECK);
        step();
        cpustate = CS_RUN;
        #1 check("abort_own", bus.mem_own, 0);
        step();
        check("abort_outs", {bus.chk_valid, bus.mem_re, bus.in_ready}, 0);
        check("abort_count", count, 3);
        step();
        check("abort_valid", bus.chk_valid, 0);
        check_run(3, 1'b0);

        // empty CHECK after reset: no reads
        reset = 1'b0;
        cpustate = CS_IDLE;
        step();
        reset = 1'b1;
        step();
        base = rd_cnt;
        set_mode(CS_CHECK);
        repeat (4) step();
        check("empty_flag", {bus.chk_empty, bus.chk_valid}, 2'b10);
        check("empty_reads", rd_cnt - base, 0);
        set_mode(CS_IDLE);

        // async reset mid-load after two bytes
        set_mode(CS_IN);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        step();
        bus.in_data  = 8'h6B;
        step();
        bus.in_valid = 1'b0;
        base = wr_cnt;
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        step();
        step();
        check("midreset_nowrite", wr_cnt - base, 0);
        cpustate = CS_IDLE;
        reset = 1'b1;
        step();
        src = '{8'h77};
        load_bytes(src, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
